imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Sits upstream of Pipe_CPU_1 and replaces bench-side memory preload. Holds the CPU in reset, zeroes
//  instruction and data memory, then loads program words from a byte stream into instruction memory.
//  Releases the CPU once the last word is written. Drives the IM/DM write ports and the CPU reset.
// PARAMETERS
//  IM_DEPTH  32   instruction memory depth in 32-bit words
//  IM_AW     5    IM word-address width (log2 IM_DEPTH)
//  DM_DEPTH  128  data memory depth in bytes
//  DM_AW     7    DM byte-address width (log2 DM_DEPTH)
// PORTS
//  clk_i       in   1      clock; all state changes on rising edge
//  rst_i       in   1      reset is asynchronous and active-high
//  start_i     in   1      one-cycle load request, sampled in IDLE/RUN only
//  n_words_i   in   IM_AW+1  number of program words to load, latched with start_i
//  s_valid_i   in   1      stream byte valid
//  s_data_i    in   8      stream byte, MSB-first within each word
//  s_ready_o   out  1      loader accepts a byte this cycle
//  im_we_o     out  1      IM word write strobe
//  im_addr_o   out  IM_AW  IM word address
//  im_wdata_o  out  32     IM write data
//  dm_we_o     out  1      DM byte write strobe
//  dm_addr_o   out  DM_AW  DM byte address
//  dm_wdata_o  out  8      DM write data (always 0)
//  cpu_rst_n_o out  1      CPU reset; 0 holds the CPU in reset
//  busy_o      out  1      high in CLR_IM, CLR_DM and LOAD
//  done_o      out  1      high in RUN
//  err_o       out  1      sticky: last start_i had n_words_i > IM_DEPTH
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, so cpu_rst_n_o=0. Word/byte counters 0. Memory contents untouched.
//  - States: IDLE -> CLR_IM -> CLR_DM -> LOAD -> RUN. Every output is registered.
//  - IDLE/RUN + start_i: if n_words_i > IM_DEPTH, set err_o and stay (RUN keeps the CPU running).
//    Otherwise clear err_o, latch N, and drop cpu_rst_n_o on the same edge. Go to CLR_IM.
//  - CLR_IM: im_we_o=1, im_wdata_o=0, im_addr_o=0..IM_DEPTH-1, one per cycle, IM_DEPTH cycles total.
//    The first write is visible in the cycle after start_i is sampled.
//  - CLR_DM: follows CLR_IM with no gap. dm_we_o=1, dm_addr_o=0..DM_DEPTH-1, DM_DEPTH cycles.
//  - After the last DM clear: N=0 -> RUN directly; otherwise -> LOAD.
//  - LOAD: s_ready_o=1. A byte is accepted when s_valid_i && s_ready_o. Accepted bytes shift in MSB-first
//    (first byte = bits 31:24).
//    The 4th accepted byte completes a word: the next cycle carries im_we_o=1, im_addr_o=word index,
//    im_wdata_o=word. Word index runs 0..N-1 and never wraps.
//    s_valid_i gaps stall assembly with no state loss; s_ready_o stays high through gaps.
//  - s_ready_o drops on the same edge that latches the final byte. The final IM write goes out in the
//    following cycle, with the state moving to RUN on that edge.
//  - RUN: cpu_rst_n_o=1 and done_o=1 starting the cycle after the final IM write (or after the last DM
//    clear when N=0).
//  - Outside LOAD, s_ready_o=0 and stream bytes are not consumed. start_i in CLR_IM/CLR_DM/LOAD is ignored.
//  - im_we_o and dm_we_o are never high in the same cycle. Strobes are 0 in IDLE and RUN.
//  - rst_i mid-operation: immediate return to IDLE with cpu_rst_n_o=0. A partial word is discarded.
//    Memory contents already written remain.
// TESTING
//  1 rst_i pulse mid-CLR_DM -> all outputs 0 asynchronously; IDLE; next start_i restarts from IM addr 0.
//  2 start_i, N=0 -> 32 IM zero-writes, then 128 DM zero-writes back-to-back;
//    cpu_rst_n_o=1 and done_o=1 exactly 161 cycles after the start edge.
//  3 N=2, bytes 20 01 00 0A 8C 02 00 04 with no gaps -> IM[0]=0x2001000A, IM[1]=0x8C020004.
//    cpu_rst_n_o rises the cycle after the IM[1] write.
//  4 N=1, s_valid_i toggling 1/0 each cycle -> s_ready_o held high; single write IM[0] with the correct word.
//  5 N=33 -> err_o=1, no writes, state stays IDLE; then N=1 -> err_o clears and the load proceeds.
//  6 start_i during RUN with N=1 -> cpu_rst_n_o=0 next cycle; full clear and reload; RUN again.

Source files
------------

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - holds the CPU in reset, clears IM/DM, loads IM from a byte stream, then releases the CPU
module imem_boot_loader #(
    parameter int IM_DEPTH = 32,
    parameter int IM_AW    = 5,
    parameter int DM_DEPTH = 128,
    parameter int DM_AW    = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [IM_AW:0]   n_words_i,
    input  logic             s_valid_i,
    input  logic [7:0]       s_data_i,
    output logic             s_ready_o,
    output logic             im_we_o,
    output logic [IM_AW-1:0] im_addr_o,
    output logic [31:0]      im_wdata_o,
    output logic             dm_we_o,
    output logic [DM_AW-1:0] dm_addr_o,
    output logic [7:0]       dm_wdata_o,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLR_IM, S_CLR_DM, S_LOAD, S_RUN
    } state_t;

    localparam logic [IM_AW:0]   IM_DEPTH_W = IM_DEPTH[IM_AW:0];
    localparam logic [IM_AW-1:0] IM_LAST    = IM_AW'(IM_DEPTH - 1);
    localparam logic [DM_AW-1:0] DM_LAST    = DM_AW'(DM_DEPTH - 1);

    state_t           state_q;
    logic [IM_AW:0]   n_q;
    logic [IM_AW:0]   word_q;
    logic [1:0]       byte_q;
    logic [23:0]      shift_q;
    logic             im_we_q;
    logic [IM_AW-1:0] im_addr_q;
    logic [31:0]      im_wdata_q;
    logic             dm_we_q;
    logic [DM_AW-1:0] dm_addr_q;
    logic             s_ready_q;
    logic             cpu_rst_n_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [31:0]      word_d;
    logic             last_word_d;

    assign word_d      = {shift_q, s_data_i};
    assign last_word_d = (word_q == n_q - 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            s_ready_q   <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            dm_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (start_i) begin
                        if (n_words_i > IM_DEPTH_W) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q       <= 1'b0;
                            n_q         <= n_words_i;
                            word_q      <= '0;
                            byte_q      <= '0;
                            state_q     <= S_CLR_IM;
                            im_we_q     <= 1'b1;
                            im_addr_q   <= '0;
                            im_wdata_q  <= '0;
                            cpu_rst_n_q <= 1'b0;
                            done_q      <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                S_CLR_IM: begin
                    if (im_addr_q == IM_LAST) begin
                        state_q   <= S_CLR_DM;
                        dm_we_q   <= 1'b1;
                        dm_addr_q <= '0;
                    end else begin
                        im_we_q   <= 1'b1;
                        im_addr_q <= im_addr_q + 1'b1;
                    end
                end
                S_CLR_DM: begin
                    if (dm_addr_q == DM_LAST) begin
                        if (n_q == '0) begin
                            state_q     <= S_RUN;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD;
                            s_ready_q <= 1'b1;
                        end
                    end else begin
                        dm_we_q   <= 1'b1;
                        dm_addr_q <= dm_addr_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    // s_ready low inside LOAD marks the cycle carrying the final IM write
                    if (!s_ready_q) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end else if (s_valid_i) begin
                        if (byte_q == 2'd3) begin
                            im_we_q    <= 1'b1;
                            im_addr_q  <= word_q[IM_AW-1:0];
                            im_wdata_q <= word_d;
                            word_q     <= word_q + 1'b1;
                            byte_q     <= '0;
                            if (last_word_d) begin
                                s_ready_q <= 1'b0;
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], s_data_i};
                            byte_q  <= byte_q + 2'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready_o   = s_ready_q;
    assign im_we_o     = im_we_q;
    assign im_addr_o   = im_addr_q;
    assign im_wdata_o  = im_wdata_q;
    assign dm_we_o     = dm_we_q;
    assign dm_addr_o   = dm_addr_q;
    assign dm_wdata_o  = 8'h00;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule
